// File: rtl/fetch_pc_unit.sv
// Instruction fetch PC unit.
// Holds the fetch PC and runs a three-state fetch handshake (IDLE/REQ/HOLD)
// against an instruction memory. It captures returned words for a downstream
// consumer and applies branch and jump redirects. A redirect that arrives while
// a memory request is outstanding is remembered so that the stale data is dropped.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic        jump,
    input  logic [31:0] branch_base,
    input  logic [31:0] branch_offset,
    input  logic [25:0] jump_index,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    logic [1:0]  state_reg,         state_next;
    logic [31:0] pc_reg,            pc_next;
    logic [31:0] imem_addr_reg,     imem_addr_next;
    logic [31:0] instr_reg,         instr_next;
    logic [31:0] instr_pc_reg,      instr_pc_next;
    logic        instr_valid_reg,   instr_valid_next;
    logic        flush_pending_reg, flush_pending_next;
    // Low for the first edge after reset release, so the first request is
    // launched no earlier than the second rising edge.
    logic        started_reg;

    logic        redirect;
    logic [31:0] branch_sum;
    logic [31:0] target;

    assign redirect   = jump | branch_taken;
    assign branch_sum = branch_base + branch_offset;

    // Redirect target: jump wins over branch; word alignment is forced.
    always_comb begin
        target = 32'h0;
        if (jump) begin
            target = {branch_base[31:28], jump_index, 2'b00};
        end else begin
            target = branch_sum & 32'hFFFF_FFFC;
        end
    end

    assign pc_plus4    = pc_reg + 32'd4;
    assign pc          = pc_reg;
    assign imem_addr   = imem_addr_reg;
    assign instr       = instr_reg;
    assign instr_pc    = instr_pc_reg;
    assign instr_valid = instr_valid_reg;
    // Derived from state so an asynchronous reset drops it immediately.
    assign imem_req    = (state_reg == REQ);

    // Next-state logic for the fetch FSM, the PC and the capture registers.
    always_comb begin
        state_next         = state_reg;
        pc_next            = pc_reg;
        imem_addr_next     = imem_addr_reg;
        instr_next         = instr_reg;
        instr_pc_next      = instr_pc_reg;
        instr_valid_next   = instr_valid_reg;
        flush_pending_next = flush_pending_reg;

        if (redirect) begin
            pc_next = target;
        end

        case (state_reg)
            IDLE: begin
                if (started_reg && !stall && !redirect) begin
                    state_next     = REQ;
                    imem_addr_next = pc_reg;
                end
            end
            REQ: begin
                if (imem_ack) begin
                    if (flush_pending_reg || redirect) begin
                        // Stale word: drop it and refetch from the current PC.
                        flush_pending_next = 1'b0;
                        if (!stall) begin
                            state_next     = REQ;
                            imem_addr_next = redirect ? target : pc_reg;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        instr_next       = imem_rdata;
                        instr_pc_next    = imem_addr_reg;
                        instr_valid_next = 1'b1;
                        pc_next          = pc_plus4;
                        state_next       = HOLD;
                    end
                end else if (redirect) begin
                    // The request stays outstanding; its data is dropped later.
                    flush_pending_next = 1'b1;
                end
            end
            HOLD: begin
                if (instr_ready || redirect) begin
                    instr_valid_next = 1'b0;
                    if (!stall) begin
                        state_next     = REQ;
                        imem_addr_next = redirect ? target : pc_reg;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg         <= IDLE;
            pc_reg            <= RESET_PC;
            imem_addr_reg     <= 32'h0;
            instr_reg         <= 32'h0;
            instr_pc_reg      <= 32'h0;
            instr_valid_reg   <= 1'b0;
            flush_pending_reg <= 1'b0;
            started_reg       <= 1'b0;
        end else begin
            state_reg         <= state_next;
            pc_reg            <= pc_next;
            imem_addr_reg     <= imem_addr_next;
            instr_reg         <= instr_next;
            instr_pc_reg      <= instr_pc_next;
            instr_valid_reg   <= instr_valid_next;
            flush_pending_reg <= flush_pending_next;
            started_reg       <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Testbench for fetch_pc_unit: directed scenarios followed by a randomized
// run checked against a program-order model of the delivered instruction stream.
module tb_fetch_pc_unit;

    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic        jump;
    logic [31:0] branch_base;
    logic [31:0] branch_offset;
    logic [25:0] jump_index;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] pc;
    logic [31:0] pc_plus4;

    int total = 0;
    int bad   = 0;

    fetch_pc_unit #(.RESET_PC(RPC)) dut (
        .clock        (clock),
        .reset        (reset),
        .stall        (stall),
        .branch_taken (branch_taken),
        .jump         (jump),
        .branch_base  (branch_base),
        .branch_offset(branch_offset),
        .jump_index   (jump_index),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .instr        (instr),
        .instr_pc     (instr_pc),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .pc           (pc),
        .pc_plus4     (pc_plus4)
    );

    always #5 clock = ~clock;

    // Memory contents as a fixed function of the word address.
    function automatic logic [31:0] memfn(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_1234;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Wait for a request, check its address, ack one cycle later, check capture.
    task automatic deliver(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] a4;
        int n;
        n = 0;
        a4 = a + 32'd4;
        while (imem_req !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk("req_seen", {31'b0, imem_req}, 32'd1);
        chk("req_addr", imem_addr, a);
        @(negedge clock);
        chk("addr_stable", imem_addr, a);
        imem_ack   = 1'b1;
        imem_rdata = d;
        @(negedge clock);
        imem_ack = 1'b0;
        chk("cap_valid", {31'b0, instr_valid}, 32'd1);
        chk("cap_instr", instr, d);
        chk("cap_pc", instr_pc, a);
        chk("pc_inc", pc, a4);
        $display("fetch addr=%h data=%h", a, d);
    endtask

    logic        rd;
    logic        p_wait;
    logic        p_keep;
    logic [31:0] p_addr;
    logic [31:0] p_instr;
    logic [31:0] p_ipc;
    logic [31:0] exp_pc;
    int          n_del;

    initial begin
        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
        branch_base = 32'h0; branch_offset = 32'h0; jump_index = 26'h0;
        imem_ack = 1'b0; imem_rdata = 32'h0; instr_ready = 1'b1;

        // Reset state
        @(negedge clock);
        chk("rst_pc", pc, RPC);
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_ipc", instr_pc, 32'h0);
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_pc4", pc_plus4, RPC + 32'd4);
        reset = 1'b0;
        @(negedge clock);
        chk("no_req_first_edge", {31'b0, imem_req}, 32'd0);

        // Sequential fetch 0,4,8
        deliver(32'h0, 32'h1111_0000);
        deliver(32'h4, 32'h1111_0004);
        deliver(32'h8, 32'h1111_0008);

        // Hold with instr_ready low for 5 cycles
        instr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("hold_valid", {31'b0, instr_valid}, 32'd1);
            chk("hold_instr", instr, 32'h1111_0008);
            chk("hold_noreq", {31'b0, imem_req}, 32'd0);
        end
        instr_ready = 1'b1;
        @(negedge clock);
        chk("accept_valid", {31'b0, instr_valid}, 32'd0);
        chk("accept_req", {31'b0, imem_req}, 32'd1);
        chk("accept_addr", imem_addr, 32'hC);
        $display("hold released next addr=%h", imem_addr);

        // Branch redirect while request outstanding, ack two cycles later
        branch_taken = 1'b1; branch_base = 32'h100; branch_offset = 32'hFFFF_FFF0;
        @(negedge clock);
        branch_taken = 1'b0;
        chk("br_pc", pc, 32'hF0);
        chk("br_req_kept", {31'b0, imem_req}, 32'd1);
        chk("br_addr_kept", imem_addr, 32'hC);
        @(negedge clock);
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        @(negedge clock);
        imem_ack = 1'b0;
        chk("flush_valid", {31'b0, instr_valid}, 32'd0);
        chk("flush_req", {31'b0, imem_req}, 32'd1);
        chk("flush_addr", imem_addr, 32'hF0);
        $display("flushed ack, refetch addr=%h", imem_addr);
        deliver(32'hF0, 32'h2222_00F0);

        // Jump redirect from HOLD
        jump = 1'b1; branch_base = 32'h1000_0004; jump_index = 26'h40;
        @(negedge clock);
        jump = 1'b0;
        chk("jmp_pc", pc, 32'h1000_0100);
        chk("jmp_addr", imem_addr, 32'h1000_0100);
        deliver(32'h1000_0100, 32'h3333_0100);

        // Jump and branch together: jump wins
        jump = 1'b1; branch_taken = 1'b1; jump_index = 26'h3;
        branch_base = 32'h2000_0000; branch_offset = 32'h40;
        @(negedge clock);
        jump = 1'b0; branch_taken = 1'b0;
        chk("prio_pc", pc, 32'h2000_000C);
        deliver(32'h2000_000C, 32'h4444_000C);

        // Unaligned branch sum has its low bits cleared
        branch_taken = 1'b1; branch_base = 32'h200; branch_offset = 32'h13;
        @(negedge clock);
        branch_taken = 1'b0;
        chk("align_pc", pc, 32'h210);
        deliver(32'h210, 32'h5555_0210);

        // PC wrap
        jump = 1'b1; branch_base = 32'hF000_0000; jump_index = 26'h3FF_FFFF;
        @(negedge clock);
        jump = 1'b0;
        chk("wrap_pc", pc, 32'hFFFF_FFFC);
        chk("wrap_pc4", pc_plus4, 32'h0);
        deliver(32'hFFFF_FFFC, 32'h6666_FFFC);
        @(negedge clock);
        chk("wrap_req", {31'b0, imem_req}, 32'd1);
        chk("wrap_addr", imem_addr, 32'h0);
        deliver(32'h0, 32'h7777_0000);
        @(negedge clock);
        chk("pre_rst_addr", imem_addr, 32'h4);
        chk("pre_rst_pc", pc, 32'h4);

        // Asynchronous reset mid-request
        #2 reset = 1'b1;
        #1;
        chk("arst_req", {31'b0, imem_req}, 32'd0);
        chk("arst_pc", pc, RPC);
        chk("arst_valid", {31'b0, instr_valid}, 32'd0);
        imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("late_ack_req", {31'b0, imem_req}, 32'd0);
        chk("late_ack_valid", {31'b0, instr_valid}, 32'd0);
        imem_ack = 1'b0;
        $display("reset mid-request done pc=%h", pc);

        // Randomized run against the program-order model
        exp_pc = RPC; n_del = 0; p_wait = 1'b0; p_keep = 1'b0;
        p_addr = 32'h0; p_instr = 32'h0; p_ipc = 32'h0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clock);
            if (p_wait) begin
                chk("r_req_hold", {31'b0, imem_req}, 32'd1);
                chk("r_addr_hold", imem_addr, p_addr);
            end
            if (p_keep) begin
                chk("r_valid_hold", {31'b0, instr_valid}, 32'd1);
                chk("r_instr_hold", instr, p_instr);
                chk("r_ipc_hold", instr_pc, p_ipc);
            end
            stall         = ($urandom_range(0, 3) == 0);
            instr_ready   = 1'($urandom_range(0, 1));
            rd            = ($urandom_range(0, 15) == 0);
            branch_base   = $urandom;
            branch_offset = $urandom;
            jump_index    = 26'($urandom);
            if (rd) begin
                jump         = 1'($urandom_range(0, 1));
                branch_taken = jump ? 1'($urandom_range(0, 1)) : 1'b1;
            end else begin
                jump         = 1'b0;
                branch_taken = 1'b0;
            end
            imem_ack   = imem_req && ($urandom_range(0, 1) == 1);
            imem_rdata = memfn(imem_addr);
            if (instr_valid && instr_ready) begin
                chk("r_deliv_pc", instr_pc, exp_pc);
                chk("r_deliv_data", instr, memfn(instr_pc));
                $display("deliver pc=%h instr=%h", instr_pc, instr);
                exp_pc = instr_pc + 32'd4;
                n_del++;
            end
            if (rd) begin
                if (jump) exp_pc = {branch_base[31:28], jump_index, 2'b00};
                else      exp_pc = (branch_base + branch_offset) & 32'hFFFF_FFFC;
            end
            p_wait  = imem_req && !imem_ack;
            p_addr  = imem_addr;
            p_keep  = instr_valid && !instr_ready && !rd;
            p_instr = instr;
            p_ipc   = instr_pc;
        end
        chk("r_liveness", {31'b0, (n_del > 100)}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
